// File: rtl/acq_peak_search.sv
// Peak search over one full code-phase scan: tracks the largest power, its phase and the runner-up, then issues a hit/miss decision.
// Optional feature macro: ACQ_SEC_PEAK_EN enables second-peak tracking and the peak-to-second ratio test.
module acq_peak_search #(
  parameter int CORR_ACC_WIDTH = 48,
  parameter int PRN_PHS_WIDTH  = 12,
  parameter int RATIO_SHIFT    = 1
) (
  input  logic                      rx_clk,
  input  logic                      rx_rst,
  input  logic [CORR_ACC_WIDTH-1:0] rx_corr_pow,
  input  logic                      rx_pow_vld,
  input  logic                      rx_scan_sop,
  input  logic                      rx_scan_eop,
  input  logic [CORR_ACC_WIDTH-1:0] rx_thresh,
  output logic [CORR_ACC_WIDTH-1:0] tx_peak_pow,
  output logic [CORR_ACC_WIDTH-1:0] tx_sec_pow,
  output logic [PRN_PHS_WIDTH-1:0]  tx_peak_phs,
  output logic                      tx_acq_hit,
  output logic                      tx_acq_done,
  output logic                      tx_busy,
  output logic [1:0]                dbg_state
);

  // rx_pow_vld is a single-cycle pulse with no backpressure: a pulse is consumed in the
  // cycle it is high, or dropped if it arrives while the block is deciding.

  localparam int XW = CORR_ACC_WIDTH + RATIO_SHIFT;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DECIDE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                    state;
  logic [CORR_ACC_WIDTH-1:0] max_pow;
  logic [PRN_PHS_WIDTH-1:0]  max_phs;
  logic [PRN_PHS_WIDTH-1:0]  phs_cnt;
  logic                      start;
  logic                      pow_gt_max;
  logic                      thresh_ok;
  logic                      ratio_ok;
  logic                      hit;

  assign start      = rx_pow_vld & rx_scan_sop;
  assign pow_gt_max = rx_corr_pow > max_pow;
  assign thresh_ok  = max_pow > rx_thresh;
  assign hit        = thresh_ok & ratio_ok;
  assign dbg_state  = state;

`ifdef ACQ_SEC_PEAK_EN
  logic [CORR_ACC_WIDTH-1:0] sec_pow;
  logic [XW-1:0]             max_wide;
  logic [XW-1:0]             sec_wide;
  logic                      pow_gt_sec;

  assign pow_gt_sec = rx_corr_pow > sec_pow;
  // Widened so the shifted runner-up never loses its top bits.
  assign max_wide   = XW'(max_pow);
  assign sec_wide   = XW'(sec_pow) << RATIO_SHIFT;
  assign ratio_ok   = max_wide >= sec_wide;

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      sec_pow    <= '0;
      tx_sec_pow <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) sec_pow <= '0;
        end
        ST_SCAN: begin
          if (rx_pow_vld) begin
            if (rx_scan_sop)     sec_pow <= '0;
            else if (pow_gt_max) sec_pow <= max_pow;
            else if (pow_gt_sec) sec_pow <= rx_corr_pow;
          end
        end
        ST_DECIDE: tx_sec_pow <= sec_pow;
        default: ;
      endcase
    end
  end
`else
  assign ratio_ok   = 1'b1;
  assign tx_sec_pow = '0;
`endif

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state       <= ST_IDLE;
      max_pow     <= '0;
      max_phs     <= '0;
      phs_cnt     <= '0;
      tx_peak_pow <= '0;
      tx_peak_phs <= '0;
      tx_acq_hit  <= 1'b0;
      tx_acq_done <= 1'b0;
      tx_busy     <= 1'b0;
    end else begin
      tx_acq_done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            max_pow <= rx_corr_pow;
            max_phs <= '0;
            phs_cnt <= PRN_PHS_WIDTH'(1);
            tx_busy <= 1'b1;
            state   <= rx_scan_eop ? ST_DECIDE : ST_SCAN;
          end else begin
            state   <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (rx_pow_vld) begin
            // A fresh sop abandons the partial scan without reporting it.
            if (rx_scan_sop) begin
              max_pow <= rx_corr_pow;
              max_phs <= '0;
              phs_cnt <= PRN_PHS_WIDTH'(1);
            end else begin
              if (pow_gt_max) begin
                max_pow <= rx_corr_pow;
                max_phs <= phs_cnt;
              end
              phs_cnt <= phs_cnt + 1'b1;
            end
            if (rx_scan_eop) state <= ST_DECIDE;
          end
        end
        ST_DECIDE: begin
          tx_peak_pow <= max_pow;
          tx_peak_phs <= max_phs;
          tx_acq_hit  <= hit;
          tx_acq_done <= 1'b1;
          tx_busy     <= 1'b0;
          state       <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_peak_search.sv
// Self-checking bench for acq_peak_search: directed scans plus random scans, results checked through an expected-result queue.
module tb_acq_peak_search;

  localparam int W = 48;
  localparam int P = 12;
`ifdef ACQ_SEC_PEAK_EN
  localparam bit SEC_EN = 1'b1;
`else
  localparam bit SEC_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] peak;
    logic [W-1:0] sec;
    logic [P-1:0] phs;
    logic         hit;
  } res_t;

  logic         rx_clk;
  logic         rx_rst;
  logic [W-1:0] rx_corr_pow;
  logic         rx_pow_vld;
  logic         rx_scan_sop;
  logic         rx_scan_eop;
  logic [W-1:0] rx_thresh;
  logic [W-1:0] tx_peak_pow;
  logic [W-1:0] tx_sec_pow;
  logic [P-1:0] tx_peak_phs;
  logic         tx_acq_hit;
  logic         tx_acq_done;
  logic         tx_busy;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  res_t exp_q[$];
  logic [W-1:0] pq[$];

  acq_peak_search dut (
    .rx_clk      (rx_clk),
    .rx_rst      (rx_rst),
    .rx_corr_pow (rx_corr_pow),
    .rx_pow_vld  (rx_pow_vld),
    .rx_scan_sop (rx_scan_sop),
    .rx_scan_eop (rx_scan_eop),
    .rx_thresh   (rx_thresh),
    .tx_peak_pow (tx_peak_pow),
    .tx_sec_pow  (tx_sec_pow),
    .tx_peak_phs (tx_peak_phs),
    .tx_acq_hit  (tx_acq_hit),
    .tx_acq_done (tx_acq_done),
    .tx_busy     (tx_busy),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    rx_clk = 1'b0;
    forever #5 rx_clk = ~rx_clk;
  end

  always @(negedge rx_clk) if (tx_acq_done === 1'b1) done_cnt++;

  function automatic res_t mk(input logic [W-1:0] peak, input logic [W-1:0] sec,
                              input logic [P-1:0] phs, input logic hit);
    res_t r;
    r.peak = peak; r.sec = sec; r.phs = phs; r.hit = hit;
    return r;
  endfunction

  // Reference: strict comparisons, earliest phase wins, ratio uses shift of 1.
  function automatic res_t model(input logic [W-1:0] thresh);
    logic [W-1:0] mx, sc;
    logic [P-1:0] ph;
    logic         ratio;
    mx = pq[0]; sc = '0; ph = '0;
    for (int i = 1; i < pq.size(); i++) begin
      if (pq[i] > mx) begin
        sc = mx; mx = pq[i]; ph = P'(i);
      end else if (pq[i] > sc) begin
        sc = pq[i];
      end
    end
    ratio = SEC_EN ? ({1'b0, mx} >= {sc, 1'b0}) : 1'b1;
    return mk(mx, SEC_EN ? sc : '0, ph, (mx > thresh) && ratio);
  endfunction

  // driver tasks: called at a falling edge, return at the next falling edge
  task automatic send(input logic [W-1:0] p, input logic sop, input logic eop);
    rx_corr_pow = p; rx_pow_vld = 1'b1; rx_scan_sop = sop; rx_scan_eop = eop;
    @(negedge rx_clk);
    rx_pow_vld = 1'b0; rx_scan_sop = 1'b0; rx_scan_eop = 1'b0;
  endtask

  task automatic drive_scan();
    for (int i = 0; i < pq.size(); i++) begin
      send(pq[i], i == 0, i == pq.size() - 1);
      if (i != pq.size() - 1) repeat ($urandom_range(0, 1)) @(negedge rx_clk);
    end
  endtask

  // Waits (bounded) for the done pulse; lat counts edges since the eop valid was sampled.
  task automatic collect(output res_t got, output int lat, output bit ok);
    lat = 1;
    while (tx_acq_done !== 1'b1 && lat < 20) begin
      @(negedge rx_clk);
      lat++;
    end
    ok  = (tx_acq_done === 1'b1);
    got = mk(tx_peak_pow, tx_sec_pow, tx_peak_phs, tx_acq_hit);
  endtask

  task automatic test_reset();
    rx_rst = 1'b1;
    rx_corr_pow = '0; rx_pow_vld = 1'b0; rx_scan_sop = 1'b0; rx_scan_eop = 1'b0; rx_thresh = '0;
    repeat (2) @(negedge rx_clk);
    rx_rst = 1'b0;
    @(negedge rx_clk);
    n_checks++;
    if ({tx_peak_pow, tx_sec_pow, tx_peak_phs, tx_acq_hit} !== '0)
      $display("FAIL reset_outputs: got peak=%0d sec=%0d phs=%0d hit=%0d, expected all 0",
               tx_peak_pow, tx_sec_pow, tx_peak_phs, tx_acq_hit);
    else n_pass++;
    n_checks++;
    if ({tx_acq_done, tx_busy, dbg_state} !== 4'b0)
      $display("FAIL reset_ctrl: got done=%0d busy=%0d state=%0d, expected 0 0 0",
               tx_acq_done, tx_busy, dbg_state);
    else n_pass++;
  endtask

  task automatic test_tie_scan();
    res_t got, e; int lat; bit ok;
    rx_thresh = 20;
    pq = '{5, 9, 3, 40, 7, 12, 40, 1};
    exp_q.push_back(mk(40, SEC_EN ? 40 : 0, 3, SEC_EN ? 1'b0 : 1'b1));
    drive_scan();
    collect(got, lat, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== e)
      $display("FAIL tie_scan: done=%0d peak=%0d sec=%0d phs=%0d hit=%0d, expected peak=%0d sec=%0d phs=%0d hit=%0d",
               ok, got.peak, got.sec, got.phs, got.hit, e.peak, e.sec, e.phs, e.hit);
    else n_pass++;
  endtask

  task automatic test_thresh();
    res_t got, e; int lat; bit ok;
    rx_thresh = 50;
    exp_q.push_back(mk(100, SEC_EN ? 45 : 0, 1, 1'b1));
    send(10, 1'b1, 1'b0);
    n_checks++;
    if (tx_busy !== 1'b1) $display("FAIL busy_rise: got %0d, expected 1", tx_busy);
    else n_pass++;
    send(100, 1'b0, 1'b0);
    send(30, 1'b0, 1'b0);
    send(45, 1'b0, 1'b1);
    n_checks++;
    if ({tx_busy, tx_acq_done} !== 2'b10)
      $display("FAIL decide_ctrl: got busy=%0d done=%0d, expected busy=1 done=0", tx_busy, tx_acq_done);
    else n_pass++;
    collect(got, lat, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== e)
      $display("FAIL thresh_hit: done=%0d peak=%0d sec=%0d phs=%0d hit=%0d, expected peak=%0d sec=%0d phs=%0d hit=%0d",
               ok, got.peak, got.sec, got.phs, got.hit, e.peak, e.sec, e.phs, e.hit);
    else n_pass++;
    n_checks++;
    if (lat != 2) $display("FAIL done_latency: got %0d cycles, expected 2", lat);
    else n_pass++;
    n_checks++;
    if (tx_busy !== 1'b0) $display("FAIL busy_fall: got %0d in done cycle, expected 0", tx_busy);
    else n_pass++;
  endtask

  task automatic test_thresh_equal();
    res_t got, e; int lat; bit ok;
    rx_thresh = 100;
    pq = '{10, 100, 30, 45};
    exp_q.push_back(mk(100, SEC_EN ? 45 : 0, 1, 1'b0));
    drive_scan();
    collect(got, lat, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== e)
      $display("FAIL thresh_equal: done=%0d peak=%0d sec=%0d phs=%0d hit=%0d, expected peak=%0d sec=%0d phs=%0d hit=%0d",
               ok, got.peak, got.sec, got.phs, got.hit, e.peak, e.sec, e.phs, e.hit);
    else n_pass++;
  endtask

  task automatic test_single();
    res_t got, e; int lat; bit ok;
    rx_thresh = 0;
    exp_q.push_back(mk(7, 0, 0, 1'b1));
    send(7, 1'b1, 1'b1);
    collect(got, lat, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== e || lat != 2)
      $display("FAIL single: done=%0d lat=%0d peak=%0d sec=%0d phs=%0d hit=%0d, expected lat=2 peak=%0d sec=%0d phs=%0d hit=%0d",
               ok, lat, got.peak, got.sec, got.phs, got.hit, e.peak, e.sec, e.phs, e.hit);
    else n_pass++;
    @(negedge rx_clk);
    n_checks++;
    if ({tx_acq_done, dbg_state} !== 3'b000)
      $display("FAIL done_pulse: got done=%0d state=%0d a cycle later, expected 0 0", tx_acq_done, dbg_state);
    else n_pass++;
  endtask

  task automatic test_restart();
    res_t got, e; int lat; bit ok; int d0;
    rx_thresh = 20;
    d0 = done_cnt;
    exp_q.push_back(mk(60, SEC_EN ? 4 : 0, 1, 1'b1));
    send(50, 1'b1, 1'b0);
    send(70, 1'b0, 1'b0);
    send(2, 1'b1, 1'b0);
    send(60, 1'b0, 1'b0);
    send(4, 1'b0, 1'b1);
    collect(got, lat, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== e)
      $display("FAIL restart: done=%0d peak=%0d sec=%0d phs=%0d hit=%0d, expected peak=%0d sec=%0d phs=%0d hit=%0d",
               ok, got.peak, got.sec, got.phs, got.hit, e.peak, e.sec, e.phs, e.hit);
    else n_pass++;
    repeat (3) @(negedge rx_clk);
    n_checks++;
    if (done_cnt - d0 != 1) $display("FAIL restart_done_count: got %0d pulses, expected 1", done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    res_t got, e; int lat; bit ok; int d0;
    rx_thresh = 5;
    d0 = done_cnt;
    send(30, 1'b1, 1'b0);
    send(80, 1'b0, 1'b0);
    rx_rst = 1'b1;
    #1;
    n_checks++;
    if ({tx_peak_pow, tx_sec_pow, tx_peak_phs, tx_acq_hit, tx_acq_done, tx_busy} !== '0)
      $display("FAIL mid_reset_outputs: got peak=%0d sec=%0d phs=%0d hit=%0d done=%0d busy=%0d, expected all 0",
               tx_peak_pow, tx_sec_pow, tx_peak_phs, tx_acq_hit, tx_acq_done, tx_busy);
    else n_pass++;
    @(negedge rx_clk);
    rx_rst = 1'b0;
    repeat (3) @(negedge rx_clk);
    n_checks++;
    if (done_cnt != d0 || tx_busy !== 1'b0)
      $display("FAIL mid_reset_no_done: got %0d pulses busy=%0d, expected 0 pulses busy=0", done_cnt - d0, tx_busy);
    else n_pass++;
    pq = '{3, 8, 6};
    exp_q.push_back(mk(8, SEC_EN ? 6 : 0, 1, SEC_EN ? 1'b0 : 1'b1));
    drive_scan();
    collect(got, lat, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== e)
      $display("FAIL after_reset_scan: done=%0d peak=%0d sec=%0d phs=%0d hit=%0d, expected peak=%0d sec=%0d phs=%0d hit=%0d",
               ok, got.peak, got.sec, got.phs, got.hit, e.peak, e.sec, e.phs, e.hit);
    else n_pass++;
  endtask

  task automatic test_phase_wrap();
    res_t got, e; int lat; bit ok;
    rx_thresh = 0;
    pq = {};
    for (int i = 0; i < 4098; i++) pq.push_back(1);
    pq[4097] = 500;
    exp_q.push_back(mk(500, SEC_EN ? 1 : 0, 1, 1'b1));
    drive_scan();
    collect(got, lat, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== e)
      $display("FAIL phase_wrap: done=%0d peak=%0d sec=%0d phs=%0d hit=%0d, expected peak=%0d sec=%0d phs=%0d hit=%0d",
               ok, got.peak, got.sec, got.phs, got.hit, e.peak, e.sec, e.phs, e.hit);
    else n_pass++;
  endtask

  task automatic test_random();
    res_t got, e; int lat; bit ok; int len;
    for (int s = 0; s < 6; s++) begin
      len = $urandom_range(1, 16);
      pq = {};
      for (int i = 0; i < len; i++) pq.push_back(W'($urandom_range(0, 1000)));
      rx_thresh = W'($urandom_range(0, 1000));
      exp_q.push_back(model(rx_thresh));
      drive_scan();
      collect(got, lat, ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || got !== e || lat != 2)
        $display("FAIL random_%0d: done=%0d lat=%0d peak=%0d sec=%0d phs=%0d hit=%0d, expected lat=2 peak=%0d sec=%0d phs=%0d hit=%0d",
                 s, ok, lat, got.peak, got.sec, got.phs, got.hit, e.peak, e.sec, e.phs, e.hit);
      else n_pass++;
      repeat ($urandom_range(0, 2)) @(negedge rx_clk);
    end
  endtask

  initial begin
    test_reset();
    test_tie_scan();
    test_thresh();
    test_thresh_equal();
    test_single();
    test_restart();
    test_reset_mid();
    test_phase_wrap();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d leftover, expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/acq_peak_search.md
# acq_peak_search

Downstream of the correlation accumulator in the B1 acquisition chain. One power value per code-phase hypothesis (`pow_real + pow_imag`, issued at each PRN end-of-period) is scanned across a full code-phase search. The block tracks the largest power, its phase index and the runner-up. At scan end it raises a one-cycle acquisition decision (hit or miss) for the acquisition controller.

## Interface
Parameters:
- `CORR_ACC_WIDTH`, 48: width of input power, threshold and power outputs.
- `PRN_PHS_WIDTH`, 12: width of the code-phase index (up to 4096 hypotheses).
- `RATIO_SHIFT`, 1: peak-to-second ratio test is `peak >= second << RATIO_SHIFT`.

Ports:
- `rx_clk`  in  1  sole clock.
- `rx_rst`  in  1  reset; asynchronous, active-high.
- `rx_corr_pow`  in  `CORR_ACC_WIDTH`  unsigned correlation power for the current hypothesis.
- `rx_pow_vld`  in  1  `rx_corr_pow` valid this cycle; one pulse per hypothesis.
- `rx_scan_sop`  in  1  qualifies `rx_pow_vld` as first hypothesis of a scan.
- `rx_scan_eop`  in  1  qualifies `rx_pow_vld` as last hypothesis of a scan.
- `rx_thresh`  in  `CORR_ACC_WIDTH`  detection threshold; sampled at scan end.
- `tx_peak_pow`  out  `CORR_ACC_WIDTH`  maximum power of the last completed scan.
- `tx_sec_pow`  out  `CORR_ACC_WIDTH`  second-largest power of the last completed scan.
- `tx_peak_phs`  out  `PRN_PHS_WIDTH`  phase index of `tx_peak_pow`.
- `tx_acq_hit`  out  1  decision of the last completed scan.
- `tx_acq_done`  out  1  one-cycle pulse when outputs update.
- `tx_busy`  out  1  high while a scan is in progress (SCAN or DECIDE).

## Operation
- States: IDLE, SCAN, DECIDE, DONE.
- IDLE:
  - `rx_pow_vld & rx_scan_sop` loads `max = rx_corr_pow`, `max_phs = 0`, `sec = 0`, `phs_cnt = 1`.
  - If `rx_scan_eop` is also high (single-hypothesis scan), go to DECIDE; otherwise go to SCAN.
  - Valid without sop is ignored.
- SCAN, on each `rx_pow_vld`:
  - If `pow > max`: `sec <= max`, `max <= pow`, `max_phs <= phs_cnt`.
  - Else if `pow > sec`: `sec <= pow`.
  - `phs_cnt` increments and wraps modulo 2^`PRN_PHS_WIDTH`.
  - Comparisons are strict, so on a tie the earliest phase wins.
  - Adjacent phases of the peak are not excluded from `sec`.
  - Valid with eop goes to DECIDE after updating.
  - Valid with sop restarts the scan exactly as from IDLE; the partial result is discarded and no done is issued.
- DECIDE, one cycle:
  - `hit = (max > rx_thresh) & ratio_ok`.
  - `ratio_ok` compares `max` against `{sec, RATIO_SHIFT zeros}` in `CORR_ACC_WIDTH+RATIO_SHIFT` bits, with no truncation.
  - Register all outputs, then go to DONE.
- DONE: `tx_acq_done = 1` for this cycle only, then go to IDLE. A sop valid arriving in DONE is accepted as a new scan start.
- Valid pulses during DECIDE are dropped. The upstream accumulator guarantees at least one full PRN period between pulses.
- Outputs hold their values until the next DONE.

## Timing
- Valid with eop at cycle N: DECIDE at N+1; outputs updated and `tx_acq_done` high at N+2.
- `tx_busy` rises the cycle after the sop valid and falls in the DONE cycle.
- Reset: state IDLE, and all outputs, `max`, `sec` and `phs_cnt` are 0. Reset asserted mid-scan aborts the scan with no done pulse.

## Configuration
- `ACQ_SEC_PEAK_EN` defined: second-peak tracking and the ratio test are active, as described above.
- `ACQ_SEC_PEAK_EN` undefined: the `sec` register is removed, `tx_sec_pow` is tied to 0, and `hit = max > rx_thresh`.

## Test plan
- Scan of 8 powers {5,9,3,40,7,12,40,1}, threshold 20, `RATIO_SHIFT`=1 -> `peak_pow`=40, `peak_phs`=3 (tie keeps first), `sec`=40, hit=0 (40 < 80); with macro off, hit=1.
- Powers {10,100,30,45}, threshold 50 -> peak 100 at phs 1, sec 45, hit=1; done exactly 2 cycles after eop valid.
- Same powers with threshold 100 -> hit=0 (strict greater-than).
- Single valid with sop=eop=1, power 7, threshold 0 -> peak 7, phs 0, sec 0, hit=1.
- Sop re-asserted on the third valid of a scan, then {2,60,4} with eop -> result reflects only the new scan: peak 60, phs 1, single done pulse.
- Reset asserted mid-scan -> all outputs 0, no done; the next full scan completes normally.
